// File: rtl/kmeans_pkg.sv
// Shared constants, FSM encoding and divider tag layout for the K-means
// cluster-mean datapath.
package kmeans_pkg;

    localparam int K           = 4;
    localparam int COORD_W     = 8;
    localparam int SUM_W       = 20;
    localparam int CNT_W       = 12;
    localparam int DIV_LATENCY = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Tag word is {valid, axis, empty, idx}; the index occupies the low bits
    // and the flag offsets below are counted from just above the index.
    localparam int TAG_EMPTY_OFS = 0;
    localparam int TAG_AXIS_OFS  = 1;
    localparam int TAG_VALID_OFS = 2;
    localparam int TAG_FLAGS_W   = 3;

endpackage

// File: rtl/div_tag_pipe.sv
// Fixed-depth delay line that carries operand tags alongside the external
// divider pipeline so each quotient can be matched to its cluster and axis.
module div_tag_pipe #(
    parameter int DEPTH = 24,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             en_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o
);

    logic [DEPTH-1:0][TAG_W-1:0] stage_q;

    // Advances only when the divider advances, keeping tags in lock-step.
    always_ff @(posedge clk) begin
        if (sclr) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= {stage_q[DEPTH-2:0], tag_i};
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cluster_mean_accumulator.sv
// Accumulates per-cluster sums/counts over one assignment pass, then feeds the
// pipelined divider and reassembles its quotients into one centroid per cluster.
module cluster_mean_accumulator
    import kmeans_pkg::*;
#(
    parameter int K           = kmeans_pkg::K,
    parameter int COORD_W     = kmeans_pkg::COORD_W,
    parameter int SUM_W       = kmeans_pkg::SUM_W,
    parameter int CNT_W       = kmeans_pkg::CNT_W,
    parameter int DIV_LATENCY = kmeans_pkg::DIV_LATENCY
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 start,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic [COORD_W-1:0]   pt_x,
    input  logic [COORD_W-1:0]   pt_y,
    input  logic [$clog2(K)-1:0] pt_cluster,
    input  logic                 pt_last,
    output logic                 div_ce,
    output logic [SUM_W-1:0]     div_dividend,
    output logic [CNT_W-1:0]     div_divisor,
    input  logic [SUM_W-1:0]     div_quotient,
    output logic                 mean_valid,
    output logic [$clog2(K)-1:0] mean_idx,
    output logic [SUM_W-1:0]     mean_x,
    output logic [SUM_W-1:0]     mean_y,
    output logic                 mean_empty,
    output logic                 done,
    output logic                 overflow
);

    localparam int IDX_W = $clog2(K);
    localparam int TAG_W = IDX_W + TAG_FLAGS_W;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [IDX_W:0]   ISSUE_LAST = (IDX_W+1)'(2*K-1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(K-1);

    if (SUM_W < COORD_W + CNT_W) begin : g_sum_w_check
        $error("cluster_mean_accumulator: SUM_W must be >= COORD_W + CNT_W");
    end

    state_e           state_q;
    logic [SUM_W-1:0] sum_x_q [K];
    logic [SUM_W-1:0] sum_y_q [K];
    logic [CNT_W-1:0] cnt_q   [K];
    logic [IDX_W:0]   issue_q;
    logic [SUM_W-1:0] hold_x_q;
    logic [SUM_W-1:0] mean_x_q;
    logic [SUM_W-1:0] mean_y_q;
    logic [IDX_W-1:0] mean_idx_q;
    logic             mean_valid_q;
    logic             mean_empty_q;
    logic             done_q;
    logic             overflow_q;

    logic [IDX_W-1:0] issue_k;
    logic             issue_axis;
    logic             issue_empty;
    logic             pt_fire;
    logic             pt_fits;
    logic [TAG_W-1:0] tag_d;
    logic [TAG_W-1:0] tag_q;
    logic             tag_valid;
    logic             tag_axis;
    logic             tag_empty;
    logic [IDX_W-1:0] tag_idx;

    // Issue counter walks x,y of cluster 0, then x,y of cluster 1, ...
    assign issue_k     = issue_q[IDX_W:1];
    assign issue_axis  = issue_q[0];
    assign issue_empty = (cnt_q[issue_k] == '0);

    assign pt_ready = (state_q == ST_ACCUM);
    assign pt_fire  = pt_ready && pt_valid;
    assign pt_fits  = (cnt_q[pt_cluster] != CNT_MAX);

    always_comb begin
        div_ce       = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        tag_d        = '0;
        if (state_q == ST_ISSUE) begin
            div_ce                       = 1'b1;
            tag_d[IDX_W-1:0]             = issue_k;
            tag_d[IDX_W + TAG_VALID_OFS] = 1'b1;
            tag_d[IDX_W + TAG_AXIS_OFS]  = issue_axis;
            tag_d[IDX_W + TAG_EMPTY_OFS] = issue_empty;
            if (issue_empty) begin
                div_divisor = CNT_W'(1);
            end else begin
                div_dividend = issue_axis ? sum_y_q[issue_k] : sum_x_q[issue_k];
                div_divisor  = cnt_q[issue_k];
            end
        end else if (state_q == ST_DRAIN) begin
            div_ce = 1'b1;
        end
    end

    div_tag_pipe #(
        .DEPTH (DIV_LATENCY),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk   (clk),
        .sclr  (sclr),
        .en_i  (div_ce),
        .tag_i (tag_d),
        .tag_o (tag_q)
    );

    assign tag_idx   = tag_q[IDX_W-1:0];
    assign tag_valid = tag_q[IDX_W + TAG_VALID_OFS];
    assign tag_axis  = tag_q[IDX_W + TAG_AXIS_OFS];
    assign tag_empty = tag_q[IDX_W + TAG_EMPTY_OFS];

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q      <= ST_IDLE;
            issue_q      <= '0;
            hold_x_q     <= '0;
            mean_x_q     <= '0;
            mean_y_q     <= '0;
            mean_idx_q   <= '0;
            mean_valid_q <= 1'b0;
            mean_empty_q <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            mean_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < K; i++) begin
                            sum_x_q[i] <= '0;
                            sum_y_q[i] <= '0;
                            cnt_q[i]   <= '0;
                        end
                        overflow_q <= 1'b0;
                        state_q    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (pt_fire) begin
                        if (pt_fits) begin
                            sum_x_q[pt_cluster] <= sum_x_q[pt_cluster] + SUM_W'(pt_x);
                            sum_y_q[pt_cluster] <= sum_y_q[pt_cluster] + SUM_W'(pt_y);
                            cnt_q[pt_cluster]   <= cnt_q[pt_cluster] + CNT_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        if (pt_last) begin
                            issue_q <= '0;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    issue_q <= issue_q + 1'b1;
                    if (issue_q == ISSUE_LAST) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mean_valid_q && mean_idx_q == IDX_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // x quotient arrives one cycle ahead of y; hold it so both publish together.
            if (tag_valid) begin
                if (!tag_axis) begin
                    hold_x_q <= tag_empty ? '0 : div_quotient;
                end else begin
                    mean_x_q     <= tag_empty ? '0 : hold_x_q;
                    mean_y_q     <= tag_empty ? '0 : div_quotient;
                    mean_idx_q   <= tag_idx;
                    mean_empty_q <= tag_empty;
                    mean_valid_q <= 1'b1;
                end
            end
        end
    end

    assign mean_valid = mean_valid_q;
    assign mean_idx   = mean_idx_q;
    assign mean_x     = mean_x_q;
    assign mean_y     = mean_y_q;
    assign mean_empty = mean_empty_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cluster_mean_accumulator.sv
// Randomized scoreboard bench: stimulus feeds a per-pass reference model that
// queues expected centroids; an independent monitor checks every cycle.
module tb_cluster_mean_accumulator;
    import kmeans_pkg::*;

    localparam int IDX_W   = $clog2(K);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 sclr;
    logic                 start;
    logic                 pt_valid;
    logic                 pt_ready;
    logic [COORD_W-1:0]   pt_x;
    logic [COORD_W-1:0]   pt_y;
    logic [IDX_W-1:0]     pt_cluster;
    logic                 pt_last;
    logic                 div_ce;
    logic [SUM_W-1:0]     div_dividend;
    logic [CNT_W-1:0]     div_divisor;
    logic [SUM_W-1:0]     div_quotient;
    logic                 mean_valid;
    logic [IDX_W-1:0]     mean_idx;
    logic [SUM_W-1:0]     mean_x;
    logic [SUM_W-1:0]     mean_y;
    logic                 mean_empty;
    logic                 done;
    logic                 overflow;

    always #5 clk = ~clk;

    cluster_mean_accumulator dut (
        .clk          (clk),
        .sclr         (sclr),
        .start        (start),
        .pt_valid     (pt_valid),
        .pt_ready     (pt_ready),
        .pt_x         (pt_x),
        .pt_y         (pt_y),
        .pt_cluster   (pt_cluster),
        .pt_last      (pt_last),
        .div_ce       (div_ce),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .mean_valid   (mean_valid),
        .mean_idx     (mean_idx),
        .mean_x       (mean_x),
        .mean_y       (mean_y),
        .mean_empty   (mean_empty),
        .done         (done),
        .overflow     (overflow)
    );

    // Behavioural divider: quotient appears DIV_LATENCY enabled cycles later.
    logic [SUM_W-1:0] dq [DIV_LATENCY];
    initial for (int i = 0; i < DIV_LATENCY; i++) dq[i] = '0;
    always @(posedge clk) begin
        if (div_ce) begin
            for (int i = DIV_LATENCY - 1; i > 0; i--) dq[i] <= dq[i-1];
            dq[0] <= (div_divisor == '0) ? '1 : div_dividend / SUM_W'(div_divisor);
        end
    end
    assign div_quotient = dq[DIV_LATENCY-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int     cyc;
        int     idx;
        longint x;
        longint y;
        bit     empty;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model of the current pass.
    int m_sx [K];
    int m_sy [K];
    int m_cnt[K];
    bit m_ovf;

    // Expectations published at pass end for the monitor.
    int op_sx [K];
    int op_sy [K];
    int op_cnt[K];
    int win_lo, win_hi, done_cyc, last_e;
    bit win_valid = 0;
    bit done_pend = 0;
    bit exp_ovf_done;
    bit mon_en = 0;
    bit zero_chk = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            bit     exp_ce;
            longint exp_dvd, exp_dvs;
            int     j;
            if (zero_chk) begin
                chk("reset_outputs_zero",
                    |{pt_ready, div_ce, div_dividend, div_divisor, mean_valid, mean_idx,
                      mean_x, mean_y, mean_empty, done, overflow}, 0);
                zero_chk = 0;
            end
            exp_ce  = win_valid && cyc >= win_lo && cyc <= win_hi;
            exp_dvd = 0;
            exp_dvs = 0;
            j = cyc - win_lo;
            if (exp_ce && j < 2 * K) begin
                if (op_cnt[j/2] == 0) begin
                    exp_dvs = 1;
                end else begin
                    exp_dvd = (j % 2 == 1) ? op_sy[j/2] : op_sx[j/2];
                    exp_dvs = op_cnt[j/2];
                end
            end
            chk("div_ce", div_ce, exp_ce);
            chk("div_dividend", div_dividend, exp_dvd);
            chk("div_divisor", div_divisor, exp_dvs);

            if (mean_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_mean_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("mean idx=%0d x=%0d y=%0d empty=%0d cycle=%0d",
                             mean_idx, mean_x, mean_y, mean_empty, cyc);
                    chk("mean_cycle", cyc, mon_e.cyc);
                    chk("mean_idx", mean_idx, mon_e.idx);
                    chk("mean_x", mean_x, mon_e.x);
                    chk("mean_y", mean_y, mon_e.y);
                    chk("mean_empty", mean_empty, mon_e.empty);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                chk("missing_mean_valid", 0, 1);
            end

            if (done) begin
                if (!done_pend) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, done_cyc);
                    chk("overflow_at_done", overflow, exp_ovf_done);
                    chk("means_outstanding", exp_q.size(), 0);
                    done_pend = 0;
                end
            end else if (done_pend && cyc > done_cyc) begin
                chk("done_timeout", 0, 1);
                done_pend = 0;
            end

            if (sclr) begin
                exp_q.delete();
                win_valid = 0;
                done_pend = 0;
                zero_chk  = 1;
            end
        end
    end

    task automatic push_expect(input int e);
        exp_t it;
        for (int k = 0; k < K; k++) begin
            op_sx[k]  = m_sx[k];
            op_sy[k]  = m_sy[k];
            op_cnt[k] = m_cnt[k];
            it.cyc   = e + 2 * k + 2 + DIV_LATENCY;
            it.idx   = k;
            it.empty = (m_cnt[k] == 0);
            it.x     = it.empty ? 0 : m_sx[k] / m_cnt[k];
            it.y     = it.empty ? 0 : m_sy[k] / m_cnt[k];
            exp_q.push_back(it);
        end
        win_lo       = e;
        win_hi       = e + 2 * K + DIV_LATENCY;
        win_valid    = 1;
        done_cyc     = e + 2 * K + DIV_LATENCY + 1;
        exp_ovf_done = m_ovf;
        done_pend    = 1;
        last_e       = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pt_valid = 0;
            pt_last  = 0;
            start    = 0;
        end
    endtask

    task automatic begin_pass();
        @(posedge clk); #1;
        pt_valid = 0;
        pt_last  = 0;
        start    = 1;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < K; k++) begin
            m_sx[k]  = 0;
            m_sy[k]  = 0;
            m_cnt[k] = 0;
        end
        m_ovf = 0;
        @(negedge clk);
        chk("overflow_cleared_by_start", overflow, 0);
    endtask

    task automatic send_point(input int x, input int y, input int c, input bit last,
                              input bit with_start = 0);
        bit acc = 0;
        @(posedge clk); #1;
        pt_x       = COORD_W'(x);
        pt_y       = COORD_W'(y);
        pt_cluster = IDX_W'(c);
        pt_last    = last;
        pt_valid   = 1;
        start      = with_start;
        for (int t = 0; t < 8 && !acc; t++) begin
            @(negedge clk);
            if (pt_ready) acc = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!acc) begin
            chk("pt_ready_timeout", 0, 1);
            return;
        end
        if (m_cnt[c] < CNT_MAX) begin
            m_sx[c]  += x;
            m_sy[c]  += y;
            m_cnt[c] += 1;
        end else begin
            m_ovf = 1;
        end
        if (last) push_expect(cyc + 1);
    endtask

    task automatic wait_done();
        int lim = done_cyc + 2;
        while (cyc < lim) begin
            @(posedge clk); #1;
            pt_valid = 0;
            pt_last  = 0;
            start    = 0;
        end
    endtask

    task automatic basic_points(input bit poke_start);
        send_point(10, 20, 0, 0);
        send_point(30, 40, 0, 0, poke_start);
        send_point(1, 2, 1, 0);
        send_point(2, 2, 1, 0, poke_start);
        send_point(2, 3, 1, 1);
    endtask

    task automatic random_pass(input int n, input int mask);
        begin_pass();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_point($urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, K - 1) & mask, i == n - 1);
        end
        wait_done();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running (got no finish, required finish)");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sclr       = 1;
        start      = 0;
        pt_valid   = 0;
        pt_last    = 0;
        pt_x       = '0;
        pt_y       = '0;
        pt_cluster = '0;
        @(posedge clk); #1;
        mon_en = 1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        sclr = 0;
        idle(2);

        // Hand-computed pass: (20,30), (1,2) truncated, clusters 2 and 3 empty.
        begin_pass();
        basic_points(0);
        wait_done();

        // start pulses during ACCUM must not disturb the sums.
        begin_pass();
        basic_points(1);
        wait_done();

        random_pass(20, 3);
        random_pass(35, 1);
        random_pass(1, 2);
        random_pass(40, 0);
        random_pass(25, 3);

        // Count saturation on cluster 0: trailing points are dropped, overflow sticks.
        begin_pass();
        for (int i = 0; i < CNT_MAX + 5; i++)
            send_point($urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
        send_point(3, 4, 1, 1);
        wait_done();

        random_pass(12, 3);

        // sclr in DRAIN discards the pass; nothing may emerge afterwards.
        begin_pass();
        send_point(100, 50, 2, 0);
        send_point(7, 9, 3, 1);
        begin
            int e = last_e;
            do begin
                @(posedge clk); #1;
                pt_valid = 0;
                pt_last  = 0;
            end while (cyc < e + 10);
            sclr = 1;
            @(posedge clk); #1;
            sclr = 0;
            while (cyc < e + 45) begin
                @(posedge clk); #1;
            end
        end

        begin_pass();
        basic_points(0);
        wait_done();

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
